// File: rtl/spi_target_stream.sv
// rtl/spi_target_stream.sv - SPI target that takes a 16-bit start-address header, then streams memory words out on CIPO
// and reports each word received on COPI together with its address.
module spi_target_stream #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 14,
  parameter int DEPTH       = 2**ADDR_WIDTH,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sck,
  input  logic                  cs,
  input  logic                  copi,
  output logic                  cipo,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [ADDR_WIDTH-1:0] data_address,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic [ADDR_WIDTH-1:0] rx_address,
  output logic                  rx_valid,
  output logic                  active
);

  localparam int SHW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int IW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [4:0]            WORD_LAST = 5'(DATA_WIDTH - 1);
  localparam bit SAMPLE_RISING = (CPOL == CPHA);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, copi_sync;
  logic sck_s, cs_s, copi_s, sck_d, cs_d;
  logic sample_edge, cs_rise, cs_fall;

  state_t                state_q, state_n;
  logic [4:0]            bit_cnt_q, bit_cnt_n;
  logic [SHW-2:0]        shift_q, shift_n;
  logic [SHW-1:0]        word_in;
  logic [ADDR_WIDTH-1:0] data_address_n, rx_address_n;
  logic [DATA_WIDTH-1:0] rx_data_n;
  logic                  rx_valid_n;
  logic [IW-1:0]         bit_idx;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      copi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign copi_s = copi_sync[SYNC_STAGES-1];

  assign sample_edge = SAMPLE_RISING ? (sck_s & ~sck_d) : (~sck_s & sck_d);
  assign cs_rise     = cs_s & ~cs_d;
  assign cs_fall     = ~cs_s & cs_d;

  // Only the newest SHW bits of the header or word matter, so the shifter is no wider than that.
  assign word_in = {shift_q, copi_s};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_address <= '0;
      rx_data      <= '0;
      rx_address   <= '0;
      rx_valid     <= 1'b0;
    end else begin
      state_q      <= state_n;
      bit_cnt_q    <= bit_cnt_n;
      shift_q      <= shift_n;
      data_address <= data_address_n;
      rx_data      <= rx_data_n;
      rx_address   <= rx_address_n;
      rx_valid     <= rx_valid_n;
    end
  end

  always_comb begin
    state_n        = state_q;
    bit_cnt_n      = bit_cnt_q;
    shift_n        = shift_q;
    data_address_n = data_address;
    rx_data_n      = rx_data;
    rx_address_n   = rx_address;
    rx_valid_n     = 1'b0;
    // A deselect outranks any sck edge seen in the same cycle.
    if (cs_rise) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      shift_n   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            shift_n   = '0;
          end
        end
        ADDR: begin
          if (sample_edge) begin
            shift_n = word_in[SHW-2:0];
            if (bit_cnt_q == 5'd15) begin
              data_address_n = ADDR_WIDTH'({1'b0, word_in[ADDR_WIDTH-1:0]} % DEPTH_EXT);
              bit_cnt_n      = '0;
              state_n        = DATA;
            end else begin
              bit_cnt_n = bit_cnt_q + 5'd1;
            end
          end
        end
        DATA: begin
          if (sample_edge) begin
            shift_n = word_in[SHW-2:0];
            if (bit_cnt_q == WORD_LAST) begin
              rx_data_n      = word_in[DATA_WIDTH-1:0];
              rx_address_n   = data_address;
              rx_valid_n     = 1'b1;
              data_address_n = (data_address == LAST_ADDR) ? '0 : data_address + 1'b1;
              bit_cnt_n      = '0;
            end else begin
              bit_cnt_n = bit_cnt_q + 5'd1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bit_idx = IW'(WORD_LAST - bit_cnt_q);
  assign cipo    = (state_q == DATA) & data[bit_idx];
  assign active  = (state_q != IDLE);

endmodule

// File: tb/tb_spi_target_stream.sv
// tb/tb_spi_target_stream.sv - one target per SPI mode sharing a frame memory; scoreboard on rx strobes,
// CIPO and address checked against a transfer-level model.
module tb_spi_target_stream;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int H     = 8;

  typedef struct {
    int            m;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic copi = 1'b0;
  logic [3:0] sck_v = 4'b1100;
  logic [3:0] cs_v = 4'hf;
  logic [3:0] cipo_v, rx_valid_v, active_v;
  logic [AW-1:0] daddr [4];
  logic [AW-1:0] rx_addr [4];
  logic [DW-1:0] rx_dat [4];
  logic [DW-1:0] data_v [4];
  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] exp_addr [4];
  logic [AW-1:0] exp_rx_addr [4];
  logic [DW-1:0] exp_rx_data [4];
  exp_t q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    assign data_v[g] = mem[daddr[g]];
    spi_target_stream #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
      .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(2)
    ) dut (
      .clk(clk), .reset_n(reset_n), .sck(sck_v[g]), .cs(cs_v[g]), .copi(copi),
      .cipo(cipo_v[g]), .data(data_v[g]), .data_address(daddr[g]),
      .rx_data(rx_dat[g]), .rx_address(rx_addr[g]), .rx_valid(rx_valid_v[g]),
      .active(active_v[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (rx_valid_v[m] === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: dut%0d rx_valid=1 required 0 at %0t", m, $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rx_mode", m, e.m);
          chk("rx_address", rx_addr[m], e.a);
          chk("rx_data", rx_dat[m], e.d);
        end
      end
    end
  end

  task automatic wait_h();
    repeat (H) @(negedge clk);
  endtask

  // One SPI bit from the controller's side; c is what the controller samples on CIPO.
  task automatic spi_bit(input int m, input logic b, input bit cs_at_sample, output logic c);
    logic cpol, cpha;
    cpol = (m / 2) != 0;
    cpha = (m % 2) != 0;
    if (!cpha) begin
      copi = b;
      wait_h();
      c = cipo_v[m];
      sck_v[m] = ~cpol;
      if (cs_at_sample) cs_v[m] = 1'b1;
      wait_h();
      sck_v[m] = cpol;
    end else begin
      sck_v[m] = ~cpol;
      copi = b;
      wait_h();
      c = cipo_v[m];
      sck_v[m] = cpol;
      if (cs_at_sample) cs_v[m] = 1'b1;
      wait_h();
    end
  endtask

  // end_kind 0: deselect after the partial bits; 1: deselect on the sample edge of the next bit; 2: stay selected
  task automatic xfer(input int m, input logic [15:0] hdr, input int nwords, input int fixed,
                      input int extra_bits, input int end_kind);
    logic c;
    logic [15:0] hdr_cipo;
    logic [DW-1:0] w, got;
    cs_v[m] = 1'b0;
    wait_h();
    chk("active_selected", active_v[m], 1);
    for (int i = 15; i >= 0; i--) begin
      spi_bit(m, hdr[i], 1'b0, c);
      hdr_cipo[i] = c;
    end
    chk("header_cipo_zero", hdr_cipo, 0);
    exp_addr[m] = AW'(int'(hdr[AW-1:0]) % DEPTH);
    for (int k = 0; k < nwords; k++) begin
      w = (fixed >= 0) ? DW'(fixed) : DW'($urandom);
      q.push_back('{m, exp_addr[m], w});
      exp_rx_addr[m] = exp_addr[m];
      exp_rx_data[m] = w;
      for (int i = DW - 1; i >= 0; i--) begin
        spi_bit(m, w[i], 1'b0, c);
        got[i] = c;
      end
      chk("cipo_word", got, mem[exp_addr[m]]);
      exp_addr[m] = (int'(exp_addr[m]) == DEPTH - 1) ? '0 : exp_addr[m] + 1'b1;
    end
    w = DW'($urandom);
    for (int i = 0; i < extra_bits; i++) spi_bit(m, w[DW-1-i], 1'b0, c);
    if (end_kind == 1) begin
      spi_bit(m, w[DW-1-extra_bits], 1'b1, c);
    end else if (end_kind == 0) begin
      wait_h();
      cs_v[m] = 1'b1;
    end
    if (end_kind != 2) begin
      wait_h();
      wait_h();
      chk("active_released", active_v[m], 0);
      chk("cipo_idle", cipo_v[m], 0);
      chk("data_address_end", daddr[m], exp_addr[m]);
      chk("rx_data_hold", rx_dat[m], exp_rx_data[m]);
      chk("rx_address_hold", rx_addr[m], exp_rx_addr[m]);
      chk("rx_pending", q.size(), 0);
    end
  endtask

  task automatic check_reset_state(input int m);
    chk("reset_cipo", cipo_v[m], 0);
    chk("reset_active", active_v[m], 0);
    chk("reset_rx_valid", rx_valid_v[m], 0);
    chk("reset_data_address", daddr[m], 0);
    chk("reset_rx_data", rx_dat[m], 0);
    chk("reset_rx_address", rx_addr[m], 0);
  endtask

  task automatic model_reset();
    for (int m = 0; m < 4; m++) begin
      exp_addr[m] = '0;
      exp_rx_addr[m] = '0;
      exp_rx_data[m] = '0;
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    mem[5] = 8'hA5;
    mem[6] = 8'h3C;
    model_reset();

    repeat (3) @(negedge clk);
    for (int m = 0; m < 4; m++) check_reset_state(m);
    reset_n = 1'b1;
    wait_h();

    xfer(0, 16'h0005, 2, -1, 0, 0);
    chk("t1_end_address", daddr[0], 7);

    xfer(0, 16'h000F, 3, -1, 0, 0);
    xfer(3, 16'hFFFF, 3, -1, 0, 0);

    for (int m = 1; m < 4; m++) xfer(m, 16'h0000, 1, 8'h5A, 0, 0);

    xfer(0, 16'h0009, 1, -1, 5, 0);
    xfer(0, 16'h0002, 2, -1, 0, 0);

    for (int m = 0; m < 4; m++) begin
      xfer(m, 16'($urandom), 1, -1, 7, 1);
      for (int t = 0; t < 10; t++) begin
        copi = 1'($urandom);
        sck_v[m] = ~sck_v[m];
        repeat (4) @(negedge clk);
      end
      sck_v[m] = (m / 2) != 0;
      wait_h();
      chk("deselected_active", active_v[m], 0);
      chk("deselected_cipo", cipo_v[m], 0);
      chk("deselected_address", daddr[m], exp_addr[m]);
    end

    xfer(0, 16'h0003, 1, -1, 3, 2);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int m = 0; m < 4; m++) check_reset_state(m);
    wait_h();
    cs_v[0] = 1'b1;
    wait_h();
    xfer(0, 16'h000C, 2, -1, 0, 0);

    repeat (16) begin
      int m, nw, ex, kind;
      m    = int'($urandom_range(0, 3));
      nw   = int'($urandom_range(0, 4));
      ex   = int'($urandom_range(0, DW - 1));
      kind = int'($urandom_range(0, 1));
      xfer(m, 16'($urandom), nw, -1, ex, kind);
    end

    wait_h();
    chk("rx_pending_final", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
